// File: rtl/logic_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : logic_vector_checker
// Purpose  : Built-in self-test sequencer for a 3-input combinational block.
// Revision : 1.0 - initial release
// ============================================================================
module logic_vector_checker #(
  parameter logic [7:0]  EXPECTED = 8'h31,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic [7:0] fail_vec_o
);

  localparam int unsigned   CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [3:0]    err_count_q;
  logic [7:0]    fail_vec_q;

  logic          mismatch;
  logic [3:0]    err_count_d;
  logic [7:0]    fail_vec_d;

  // Written as if/else so that an unknown y falls into the mismatch branch.
  always_comb begin
    if (y_i == EXPECTED[idx_q]) mismatch = 1'b0;
    else                        mismatch = 1'b1;
    err_count_d = err_count_q + {3'b000, mismatch};
    fail_vec_d  = fail_vec_q;
    if (mismatch) fail_vec_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 4'd0;
      fail_vec_q  <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_count_q <= 4'd0;
            fail_vec_q  <= 8'd0;
            pass_q      <= 1'b0;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == LAST_CNT) state_q <= S_CHECK;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        S_CHECK: begin
          err_count_q <= err_count_d;
          fail_vec_q  <= fail_vec_d;
          if (idx_q == 3'd7) begin
            // Verdict uses the post-vector-7 count so the last vector is included.
            pass_q  <= (err_count_d == 4'd0);
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            idx_q   <= idx_q + 3'd1;
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign {a_o, b_o, c_o} = idx_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_count_o     = err_count_q;
  assign fail_vec_o      = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_vector_checker
// Purpose  : Self-checking bench for logic_vector_checker (SETTLE=2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_vector_checker;

  localparam logic [7:0] EXP_TT = 8'h31;

  logic       clk = 1'b0;
  logic       rst_s   [2];
  logic       start_s [2];
  logic [7:0] tbl_s   [2];
  logic       y_s     [2];
  logic       a_s [2], b_s [2], c_s [2];
  logic       busy_s [2], done_s [2], pass_s [2];
  logic [3:0] err_s  [2];
  logic [7:0] fail_s [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Device under test modelled as a truth-table lookup on the stimulus.
  assign y_s[0] = tbl_s[0][{a_s[0], b_s[0], c_s[0]}];
  assign y_s[1] = tbl_s[1][{a_s[1], b_s[1], c_s[1]}];

  logic_vector_checker #(.EXPECTED(EXP_TT), .SETTLE(2)) u_dut2 (
    .clk_i(clk), .reset_i(rst_s[0]), .start_i(start_s[0]), .y_i(y_s[0]),
    .a_o(a_s[0]), .b_o(b_s[0]), .c_o(c_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .pass_o(pass_s[0]),
    .err_count_o(err_s[0]), .fail_vec_o(fail_s[0])
  );

  logic_vector_checker #(.EXPECTED(EXP_TT), .SETTLE(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst_s[1]), .start_i(start_s[1]), .y_i(y_s[1]),
    .a_o(a_s[1]), .b_o(b_s[1]), .c_o(c_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .pass_o(pass_s[1]),
    .err_count_o(err_s[1]), .fail_vec_o(fail_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] silly_tbl();
    logic [7:0] t;
    logic a, b, c;
    for (int v = 0; v < 8; v++) begin
      {a, b, c} = 3'(v);
      t[v] = (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
    end
    return t;
  endfunction

  function automatic logic [2:0] abc(input int sel);
    return {a_s[sel], b_s[sel], c_s[sel]};
  endfunction

  // One complete run from a start pulse; optionally pulses start during CHECK/FINISH.
  task automatic do_run(input int sel, input logic [7:0] tbl, input bit pulse_mid);
    int         s = (sel == 1) ? 1 : 2;
    int         d = 8 * (s + 1);
    logic [7:0] exp_fail = 8'h00;
    int         exp_err = 0;
    for (int v = 0; v < 8; v++) begin
      if (tbl[v] != EXP_TT[v]) begin
        exp_fail[v] = 1'b1;
        exp_err++;
      end
    end
    tbl_s[sel]   = tbl;
    start_s[sel] = 1'b1;
    @(negedge clk);
    start_s[sel] = 1'b0;
    for (int k = 0; k <= d + 1; k++) begin
      if (k == 0) begin
        chk("busy_at_E0", busy_s[sel], 1'b1);
        chk("pass_cleared", pass_s[sel], 1'b0);
      end
      if (k < d && (k % (s + 1)) == 0) chk("abc_step", abc(sel), 32'(k / (s + 1)));
      chk("done_timing", done_s[sel], (k == d));
      if (k == d) begin
        chk("fail_vec", fail_s[sel], exp_fail);
        chk("err_count", err_s[sel], 32'(exp_err));
        chk("pass", pass_s[sel], (exp_err == 0));
        chk("busy_in_finish", busy_s[sel], 1'b1);
      end
      if (k == d + 1) chk("busy_idle", busy_s[sel], 1'b0);
      if (pulse_mid && (k == s || k == d)) start_s[sel] = 1'b1;
      else                                 start_s[sel] = 1'b0;
      @(negedge clk);
    end
    start_s[sel] = 1'b0;
    if (pulse_mid) begin
      for (int k = 0; k < 4; k++) begin
        chk("no_rerun_busy", busy_s[sel], 1'b0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i]   = 1'b1;
      start_s[i] = 1'b0;
      tbl_s[i]   = silly_tbl();
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_abc", abc(i), 3'b000);
      chk("rst_busy", busy_s[i], 1'b0);
      chk("rst_done", done_s[i], 1'b0);
      chk("rst_pass", pass_s[i], 1'b0);
      chk("rst_err", err_s[i], 4'd0);
      chk("rst_fail", fail_s[i], 8'h00);
      rst_s[i] = 1'b0;
    end
    @(negedge clk);

    // Directed runs, SETTLE=2.
    do_run(0, silly_tbl(), 1'b0);
    do_run(0, 8'h00, 1'b0);
    do_run(0, ~silly_tbl(), 1'b0);
    do_run(0, silly_tbl(), 1'b1);

    // Directed runs, SETTLE=1.
    do_run(1, silly_tbl(), 1'b0);
    do_run(1, silly_tbl() ^ 8'h80, 1'b0);

    // Randomized truth tables on both instances.
    for (int r = 0; r < 6; r++) begin
      do_run(r % 2, 8'($urandom), 1'b0);
    end

    // Start held high: a new run every 26 cycles, one done pulse each.
    tbl_s[0]   = silly_tbl();
    start_s[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 56; k++) begin
      chk("hold_done", done_s[0], (k == 24 || k == 50));
      if (k == 25 || k == 51) chk("hold_idle_gap", busy_s[0], 1'b0);
      @(negedge clk);
    end
    start_s[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("hold_drained", busy_s[0], 1'b0);

    // Reset in the middle of vector 4's settle window.
    tbl_s[0]   = 8'h00;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int k = 0; k < 12; k++) @(negedge clk);
    chk("pre_rst_abc", abc(0), 3'd4);
    chk("pre_rst_err", err_s[0], 4'd1);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    chk("midrst_busy", busy_s[0], 1'b0);
    chk("midrst_abc", abc(0), 3'b000);
    chk("midrst_err", err_s[0], 4'd0);
    chk("midrst_fail", fail_s[0], 8'h00);
    chk("midrst_done", done_s[0], 1'b0);
    for (int k = 0; k < 30; k++) begin
      chk("post_rst_no_done", done_s[0], 1'b0);
      @(negedge clk);
    end
    do_run(0, silly_tbl(), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
